// File: rtl/gerador_varredura_abc_pkg.sv
// Shared definitions for the A/B/C sweep generator.
// Holds the FSM state encoding, the sweep mode constants, and helpers
// that map a mode to its last index and an index to the {A,B,C} vector.
package gerador_varredura_abc_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXEC   = 2'd1,
    FIM    = 2'd2
  } estado_t;

  localparam logic [1:0] MODO_FASE1 = 2'd0;
  localparam logic [1:0] MODO_FASE2 = 2'd1;
  localparam logic [1:0] MODO_FASE3 = 2'd2;
  localparam logic [1:0] MODO_TODAS = 2'd3;

  function automatic logic [3:0] ultimo_indice(input logic [1:0] modo);
    logic [3:0] ult;
    case (modo)
      MODO_FASE1: ult = 4'd3;
      MODO_FASE2: ult = 4'd3;
      MODO_FASE3: ult = 4'd7;
      default:    ult = 4'd15;
    endcase
    return ult;
  endfunction

  // Returns {A, B, C} for vector i of the given mode.
  function automatic logic [2:0] vetor_abc(input logic [1:0] modo, input logic [3:0] i);
    logic c;
    case (modo)
      MODO_FASE3: c = i[2];
      MODO_TODAS: c = i[3] & i[2];
      default:    c = 1'b0;
    endcase
    return {i[1], i[0], c};
  endfunction

endpackage

// File: rtl/gerador_varredura_abc_divisor_passo.sv
// Dwell counter for the sweep generator.
// Counts 0..DWELL-1 while enabled, wrapping to 0 after the terminal count.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   en        - advance the count this cycle
//   clr       - force the count back to 0 (has priority over en)
//   tc        - current count is DWELL-1
//   tc_prox   - count after this edge will be DWELL-1
module divisor_passo #(
  parameter int DWELL = 10,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc,
  output logic tc_prox
);

  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tc      = (cnt == ULTIMO);
  assign tc_prox = (cnt_d == ULTIMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

endmodule

// File: rtl/gerador_varredura_abc.sv
// Stimulus sequencer for decodificador_2_4: walks A/B/C through the
// selected sweep, holding each vector for DWELL cycles and strobing
// amostra on the last dwell cycle of every vector.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   start     - start request, only honoured while idle
//   pausa     - freezes counter and index while high
//   modo      - sweep selection, latched at start
//   A, B, C   - decoder inputs ({A,B} = index[1:0], C = mask)
//   valido    - a vector is being applied
//   amostra   - one-cycle sample strobe
//   indice    - current vector index
//   ocupado   - run in progress
//   fim       - one-cycle end-of-run pulse
// All outputs are registered.
module gerador_varredura_abc
  import gerador_varredura_abc_pkg::*;
#(
  parameter int DWELL = 10,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pausa,
  input  logic [1:0] modo,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       valido,
  output logic       amostra,
  output logic [3:0] indice,
  output logic       ocupado,
  output logic       fim
);

  estado_t    estado, estado_prox;
  logic [1:0] modo_q, modo_prox;
  logic [3:0] indice_prox;
  logic [2:0] abc_prox;
  logic       aceita, en, tc, tc_prox, avanca, ultimo;

  assign aceita = (estado == OCIOSO) && start;
  assign en     = (estado == EXEC) && !pausa;
  assign avanca = en && tc;
  assign ultimo = (indice == ultimo_indice(modo_q));

  divisor_passo #(
    .DWELL(DWELL),
    .CNT_W(CNT_W)
  ) u_divisor_passo (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (aceita),
    .tc     (tc),
    .tc_prox(tc_prox)
  );

  always_comb begin
    estado_prox = estado;
    modo_prox   = modo_q;
    indice_prox = indice;
    case (estado)
      OCIOSO: begin
        if (start) begin
          estado_prox = EXEC;
          modo_prox   = modo;
          indice_prox = 4'd0;
        end
      end
      EXEC: begin
        if (avanca) begin
          if (ultimo) begin
            estado_prox = FIM;
          end else begin
            indice_prox = indice + 4'd1;
          end
        end
      end
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  // Outside EXEC the last applied vector stays on A/B/C.
  assign abc_prox = (estado_prox == EXEC) ? vetor_abc(modo_prox, indice_prox) : {A, B, C};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado  <= OCIOSO;
      modo_q  <= MODO_FASE1;
      indice  <= 4'd0;
      A       <= 1'b0;
      B       <= 1'b0;
      C       <= 1'b0;
      valido  <= 1'b0;
      amostra <= 1'b0;
      ocupado <= 1'b0;
      fim     <= 1'b0;
    end else begin
      estado      <= estado_prox;
      modo_q      <= modo_prox;
      indice      <= indice_prox;
      {A, B, C}   <= abc_prox;
      valido      <= (estado_prox == EXEC);
      ocupado     <= (estado_prox == EXEC);
      fim         <= (estado_prox == FIM);
      // Registered strobe: high in the cycle whose count is DWELL-1,
      // suppressed when this edge was a paused one.
      amostra     <= (estado_prox == EXEC) && !pausa && tc_prox;
    end
  end

endmodule

// File: tb/tb_gerador_varredura_abc.sv
module tb_gerador_varredura_abc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pausa = 1'b0;
  logic [1:0] modo = 2'd0;

  logic       A, B, C, valido, amostra, ocupado, fim;
  logic [3:0] indice;
  logic       a1, b1, c1, valido1, amostra1, ocupado1, fim1;
  logic [3:0] indice1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gerador_varredura_abc #(.DWELL(10), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pausa(pausa), .modo(modo),
    .A(A), .B(B), .C(C), .valido(valido), .amostra(amostra),
    .indice(indice), .ocupado(ocupado), .fim(fim)
  );

  gerador_varredura_abc #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .pausa(pausa), .modo(modo),
    .A(a1), .B(b1), .C(c1), .valido(valido1), .amostra(amostra1),
    .indice(indice1), .ocupado(ocupado1), .fim(fim1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // k counts unpaused cycles since acceptance; index = k / dwell.
  typedef struct {
    int st;      // 0 idle, 1 running, 2 end pulse
    int modo;
    int k;
    int idx;
    bit a, b, c, valido, amostra, ocupado, fim;
  } mdl_t;

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.st = 0; r.modo = 0; r.k = 0; r.idx = 0;
    r.a = 0; r.b = 0; r.c = 0; r.valido = 0; r.amostra = 0; r.ocupado = 0; r.fim = 0;
    return r;
  endfunction

  function automatic int nvec(input int m);
    return (m == 3) ? 16 : (m == 2) ? 8 : 4;
  endfunction

  function automatic mdl_t step(input mdl_t m, input int d, input bit st_in,
                                input bit pz, input logic [1:0] md);
    mdl_t r = m;
    r.amostra = 0;
    case (m.st)
      0: if (st_in) begin r.st = 1; r.modo = int'(md); r.k = 0; end
      1: if (!pz) begin
           if (m.k + 1 >= nvec(m.modo) * d) r.st = 2;
           else r.k = m.k + 1;
         end
      default: r.st = 0;
    endcase
    r.valido  = (r.st == 1);
    r.ocupado = (r.st == 1);
    r.fim     = (r.st == 2);
    if (r.st == 1) begin
      r.idx = r.k / d;
      r.a = ((r.idx / 2) % 2) != 0;
      r.b = (r.idx % 2) != 0;
      r.c = (r.modo == 2) ? (r.idx >= 4) : (r.modo == 3) ? (r.idx >= 12) : 1'b0;
      r.amostra = ((r.k % d) == d - 1) && !pz;
    end
    return r;
  endfunction

  function automatic int pack(input mdl_t m);
    logic [3:0] i4;
    i4 = 4'(m.idx);
    return int'({m.a, m.b, m.c, m.valido, m.amostra, i4, m.ocupado, m.fim});
  endfunction

  mdl_t m10 = mdl_rst();
  mdl_t m1  = mdl_rst();

  always @(posedge clk) begin
    if (rst) begin
      m10 = mdl_rst();
      m1  = mdl_rst();
    end else begin
      m10 = step(m10, 10, start, pausa, modo);
      m1  = step(m1, 1, start, pausa, modo);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m10 = mdl_rst();
      m1  = mdl_rst();
    end
    chk("out_dwell10", int'({A, B, C, valido, amostra, indice, ocupado, fim}), pack(m10));
    chk("out_dwell1", int'({a1, b1, c1, valido1, amostra1, indice1, ocupado1, fim1}), pack(m1));
  end

  // ---------------- decoder view used for the tables ----------------
  function automatic logic [3:0] dec_y(input logic [2:0] abc);   // bits: Y0 Y1 Y2 Y3
    logic [3:0] one;
    one = 4'b1000;
    return abc[0] ? 4'b0000 : (one >> {abc[2], abc[1]});
  endfunction
  function automatic logic f2_of(input logic [2:0] abc);
    return !abc[1];
  endfunction
  function automatic logic f3_of(input logic [2:0] abc);
    return (abc[2] ^ abc[1]) & !abc[0];
  endfunction

  typedef struct {
    int         modo;
    int         idx;
    logic [2:0] abc;
    logic [3:0] y;
    logic       f2;
    logic       f3;
    bit         use_y;
    bit         use_f2;
    bit         use_f3;
  } vec_t;

  vec_t tab[12];

  logic [2:0] cap_abc[16];
  int         cap_idx[16];
  int         cap_n;

  task automatic run_seq(input logic [1:0] m, input int pause_from, input int pause_len,
                         input int start_at, input int modo_at, output int lat);
    int c;
    @(negedge clk);
    start = 1'b1;
    modo  = m;
    c     = 0;
    lat   = -1;
    cap_n = 0;
    while (c < 400 && lat < 0) begin
      @(negedge clk);
      c++;
      if (c == 1) start = 1'b0;
      if (c == start_at) start = 1'b1;
      if (start_at > 0 && c == start_at + 1) start = 1'b0;
      if (c == modo_at) modo = 2'd0;
      if (pause_len > 0 && c > pause_from && c <= pause_from + pause_len) begin
        chk("pause_indice", int'(indice), 1);
        chk("pause_amostra", int'(amostra), 0);
      end
      if (c == pause_from) pausa = 1'b1;
      if (pause_len > 0 && c == pause_from + pause_len) pausa = 1'b0;
      if (amostra) begin
        if (cap_n < 16) begin
          cap_abc[cap_n] = {A, B, C};
          cap_idx[cap_n] = int'(indice);
        end
        cap_n++;
      end
      if (fim) lat = c - 1;
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL seq_timeout: no fim within %0d cycles", c);
    end
  endtask

  task automatic check_table(input int m);
    for (int i = 0; i < 12; i++) begin
      if (tab[i].modo == m) begin
        chk("tab_indice", cap_idx[tab[i].idx], tab[i].idx);
        chk("tab_abc", int'(cap_abc[tab[i].idx]), int'(tab[i].abc));
        if (tab[i].use_y)  chk("tab_y", int'(dec_y(cap_abc[tab[i].idx])), int'(tab[i].y));
        if (tab[i].use_f2) chk("tab_f2", int'(f2_of(cap_abc[tab[i].idx])), int'(tab[i].f2));
        if (tab[i].use_f3) chk("tab_f3", int'(f3_of(cap_abc[tab[i].idx])), int'(tab[i].f3));
      end
    end
  endtask

  initial begin
    int lat;
    int w;

    tab[0]  = '{0, 0, 3'b000, 4'b1000, 1'b0, 1'b0, 1, 0, 0};
    tab[1]  = '{0, 1, 3'b010, 4'b0100, 1'b0, 1'b0, 1, 0, 0};
    tab[2]  = '{0, 2, 3'b100, 4'b0010, 1'b0, 1'b0, 1, 0, 0};
    tab[3]  = '{0, 3, 3'b110, 4'b0001, 1'b0, 1'b0, 1, 0, 0};
    tab[4]  = '{2, 0, 3'b000, 4'b0000, 1'b1, 1'b0, 0, 1, 1};
    tab[5]  = '{2, 1, 3'b010, 4'b0000, 1'b0, 1'b1, 0, 1, 1};
    tab[6]  = '{2, 2, 3'b100, 4'b0000, 1'b1, 1'b1, 0, 1, 1};
    tab[7]  = '{2, 3, 3'b110, 4'b0000, 1'b0, 1'b0, 0, 1, 1};
    tab[8]  = '{2, 4, 3'b001, 4'b0000, 1'b0, 1'b0, 0, 0, 1};
    tab[9]  = '{2, 5, 3'b011, 4'b0000, 1'b0, 1'b0, 0, 0, 1};
    tab[10] = '{2, 6, 3'b101, 4'b0000, 1'b0, 1'b0, 0, 0, 1};
    tab[11] = '{2, 7, 3'b111, 4'b0000, 1'b0, 1'b0, 0, 0, 1};

    // reset and idle
    #3;
    chk("reset_outputs", int'({A, B, C, valido, amostra, indice, ocupado, fim}), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_50", int'({A, B, C, valido, amostra, indice, ocupado, fim}), 0);

    // phase 1
    run_seq(2'd0, 0, 0, 0, 0, lat);
    chk("p1_latency", lat, 40);
    chk("p1_amostras", cap_n, 4);
    check_table(0);

    // phase 3
    run_seq(2'd2, 0, 0, 0, 0, lat);
    chk("p3_latency", lat, 80);
    chk("p3_amostras", cap_n, 8);
    check_table(2);

    // full sweep with modo changed mid-run
    run_seq(2'd3, 0, 0, 0, 50, lat);
    chk("full_latency", lat, 160);
    chk("full_amostras", cap_n, 16);
    for (int i = 0; i < 16; i++) begin
      chk("full_indice", cap_idx[i], i);
      chk("full_c", int'(cap_abc[i][0]), (i >= 12) ? 1 : 0);
    end

    // pause during index 1 plus an ignored start
    run_seq(2'd0, 13, 5, 25, 0, lat);
    chk("pause_latency", lat, 45);
    chk("pause_amostras", cap_n, 4);

    // reset in the middle of a phase 3 run
    @(negedge clk);
    start = 1'b1; modo = 2'd2;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (indice != 4'd6 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("reach_idx6", int'(indice), 6);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("async_reset", int'({A, B, C, valido, amostra, indice, ocupado, fim}), 0);
    @(posedge clk); #1 rst = 1'b0;
    run_seq(2'd2, 0, 0, 0, 0, lat);
    chk("restart_latency", lat, 80);
    chk("restart_amostras", cap_n, 8);
    for (int i = 0; i < 8; i++) chk("restart_indice", cap_idx[i], i);

    // randomized traffic, checked cycle by cycle against the model
    repeat (3000) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 15) == 0);
      pausa = ($urandom_range(0, 5) == 0);
      modo  = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; pausa = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
